// File: rtl/activation_requant_unit.sv
// Multi-lane activation + rounding requantisation stage with a two-deep
// valid/ready pipeline and a saturating count of lanes that overflowed OUT_W.
module activation_requant_unit #(
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 8,
  parameter int LANES   = 4,
  parameter int SHIFT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               cfg_mode,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [3:0]               cfg_leak_shift,
  input  logic [OUT_W-2:0]         cfg_clip,
  input  logic [LANES*ACC_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     sat_clr,
  output logic [15:0]              sat_count
);

  localparam int AW = ACC_W + 1;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2**(OUT_W-1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    MODE_IDENT = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLIP  = 2'd3
  } act_mode_e;

  // Stage S1: activated lanes plus the cfg that travels with the beat
  logic                     s1_valid_q, s1_valid_d;
  logic signed [AW-1:0]     s1_act_q [LANES];
  logic signed [AW-1:0]     s1_act_d [LANES];
  logic [SHIFT_W-1:0]       s1_shift_q;
  act_mode_e                s1_mode_q;
  logic [OUT_W-2:0]         s1_clip_q;

  // Stage S2: output registers
  logic                     out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0]   out_data_q, out_data_d;
  logic [LANES-1:0]         out_sat_q, out_sat_d;
  logic [15:0]              sat_count_q, sat_count_d;

  logic                     s1_ready, s2_ready;
  logic                     in_fire, s2_load;

  logic signed [AW-1:0]     lane_x   [LANES];
  logic signed [AW-1:0]     lane_sum [LANES];
  logic signed [AW-1:0]     lane_rnd [LANES];
  logic signed [AW-1:0]     lane_clp [LANES];
  logic signed [OUT_W-1:0]  lane_out [LANES];
  logic signed [OUT_W-1:0]  clip_ext;
  int unsigned              shamt;
  logic [16:0]              sat_inc;
  logic [16:0]              sat_sum;

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready && rst_n;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_count = sat_count_q;

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_x[l]   = {in_data[l*ACC_W + ACC_W - 1], in_data[l*ACC_W +: ACC_W]};
      s1_act_d[l] = lane_x[l];
      if (lane_x[l][AW-1]) begin
        unique case (act_mode_e'(cfg_mode))
          MODE_IDENT: s1_act_d[l] = lane_x[l];
          MODE_LEAKY: s1_act_d[l] = lane_x[l] >>> cfg_leak_shift;
          default:    s1_act_d[l] = '0;
        endcase
      end
    end
  end

  // Rounding add cannot overflow: activation never grows |x| beyond ACC_W bits.
  always_comb begin
    shamt      = 32'(s1_shift_q);
    if (shamt > ACC_W - 1) shamt = ACC_W - 1;
    clip_ext   = {1'b0, s1_clip_q};
    out_data_d = '0;
    out_sat_d  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_sum[l] = s1_act_q[l];
      lane_rnd[l] = s1_act_q[l];
      if (shamt != 0) begin
        lane_sum[l] = s1_act_q[l] + $signed(AW'(1) << (shamt - 1));
        lane_rnd[l] = lane_sum[l] >>> shamt;
      end
      lane_clp[l] = lane_rnd[l];
      if (lane_rnd[l] > SAT_MAX) begin
        lane_clp[l]  = SAT_MAX;
        out_sat_d[l] = 1'b1;
      end else if (lane_rnd[l] < SAT_MIN) begin
        lane_clp[l]  = SAT_MIN;
        out_sat_d[l] = 1'b1;
      end
      lane_out[l] = lane_clp[l][OUT_W-1:0];
      if (s1_mode_q == MODE_CLIP && lane_out[l] > clip_ext)
        lane_out[l] = clip_ext;
      out_data_d[l*OUT_W +: OUT_W] = lane_out[l];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_ready) s1_valid_d  = in_valid;
    if (s2_ready) out_valid_d = s1_valid_q;

    sat_inc = '0;
    for (int unsigned l = 0; l < LANES; l++)
      sat_inc = sat_inc + 17'(out_sat_q[l]);
    sat_sum     = {1'b0, sat_count_q} + sat_inc;
    sat_count_d = sat_count_q;
    if (sat_clr)
      sat_count_d = '0;
    else if (out_valid_q && out_ready)
      sat_count_d = sat_sum[16] ? '1 : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      sat_count_q <= sat_count_d;
      if (s2_load) out_data_q <= out_data_d;
    end
  end

  // Payload registers carry no reset; they only load on their handshake.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_act_q   <= s1_act_d;
      s1_shift_q <= cfg_shift;
      s1_mode_q  <= act_mode_e'(cfg_mode);
      s1_clip_q  <= cfg_clip;
    end
    if (s2_load) out_sat_q <= out_sat_d;
  end

endmodule

// File: tb/tb_activation_requant_unit.sv
// Directed bench for activation_requant_unit: stimulus pushes expected beats,
// an independent monitor pops and compares on every output handshake.
module tb_activation_requant_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   cfg_mode;
  logic [5:0]   cfg_shift;
  logic [3:0]   cfg_leak_shift;
  logic [6:0]   cfg_clip;
  logic [159:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sat_clr;
  logic [15:0]  sat_count;

  activation_requant_unit #(.ACC_W(40), .OUT_W(8), .LANES(4), .SHIFT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
    .cfg_leak_shift(cfg_leak_shift), .cfg_clip(cfg_clip), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sat_clr(sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          stall_prev = 0;
  logic [31:0] held;
  bit          t5_active = 0;
  int          t5_outs = 0;
  int          t5_gaps = 0;
  bit          t5_full = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] pk(input longint a, input longint b, input longint c, input longint d);
    return {d[39:0], c[39:0], b[39:0], a[39:0]};
  endfunction

  function automatic logic [31:0] pe(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic send(input logic [159:0] d, input logic [31:0] e, input bit push, input bit lat);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sbq.push_back('{e, cyc, lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(out_data), 64'(held));
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      if (t5_active && !in_ready) t5_full = 1;
      if (t5_active && t5_outs > 0 && t5_outs < 10 && !out_valid) t5_gaps++;
      if (out_valid && out_ready) begin
        if (t5_active) t5_outs++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_data", 64'(out_data), 64'(e.d));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint big_neg;
    big_neg = -(64'sd1 <<< 39);
    rst_n = 1'b0; cfg_mode = 2'd0; cfg_shift = '0; cfg_leak_shift = '0; cfg_clip = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1: ReLU, latency
    cfg_mode = 2'd1; cfg_shift = 6'd0;
    send(pk(0, -1, 1, 127), pe(0, 0, 1, 127), 1, 1);
    drain();
    chk("t1_sat", 64'(sat_count), 64'd0);

    // 2: leaky ReLU
    cfg_mode = 2'd2; cfg_leak_shift = 4'd3;
    send(pk(-64, -1, 100, -2000), pe(-8, -1, 100, -128), 1, 1);
    drain();
    chk("t2_sat", 64'(sat_count), 64'd1);

    // 3: rounding shift, then most-negative accumulator
    cfg_mode = 2'd0; cfg_shift = 6'd4;
    send(pk(24, 23, -24, 5000), pe(2, 1, -1, 127), 1, 1);
    cfg_shift = 6'd0;
    send(pk(big_neg, 0, 0, 0), pe(-128, 0, 0, 0), 1, 1);
    drain();
    chk("t3_sat", 64'(sat_count), 64'd3);

    // 4: clipped ReLU; mode change right after accept must not affect the beat
    cfg_mode = 2'd3; cfg_clip = 7'd6;
    send(pk(-5, 3, 6, 100), pe(0, 3, 6, 6), 1, 0);
    cfg_mode = 2'd1;
    drain();
    chk("t4_sat", 64'(sat_count), 64'd3);

    // 5: streaming with a 3-cycle stall
    cfg_mode = 2'd0; cfg_shift = 6'd0;
    t5_active = 1;
    fork
      for (int i = 1; i <= 10; i++) send(pk(i, 0, 0, 0), pe(i, 0, 0, 0), 1, 0);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    t5_active = 0;
    chk("t5_outs", 64'(t5_outs), 64'd10);
    chk("t5_gaps", 64'(t5_gaps), 64'd0);
    chk("t5_in_ready_fell", 64'(t5_full), 64'd1);
    chk("t5_sat", 64'(sat_count), 64'd3);

    // 6a: sat_clr wins over a simultaneous saturating handshake
    out_ready = 1'b0;
    send(pk(1000, -1000, 200, -200), pe(127, -128, 127, -128), 1, 0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        n++;
        @(posedge clk); #1;
      end
      chk("t6_wait_valid", 64'(out_valid), 64'd1);
    end
    sat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("t6_clr_priority", 64'(sat_count), 64'd0);
    send(pk(1000, -1000, 200, -200), pe(127, -128, 127, -128), 1, 0);
    drain();
    chk("t6_sat4", 64'(sat_count), 64'd4);

    // 6b: reset with two beats in flight
    out_ready = 1'b0;
    send(pk(7, 7, 7, 7), pe(7, 7, 7, 7), 0, 0);
    send(pk(8, 8, 8, 8), pe(8, 8, 8, 8), 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_in_ready", 64'(in_ready), 64'd1);
    chk("t6_post_valid", 64'(out_valid), 64'd0);
    chk("t6_post_sat", 64'(sat_count), 64'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_ghost", 64'(out_valid), 64'd0);

    // 6c: counter saturation at 16'hFFFF
    for (int i = 0; i < 16383; i++)
      send(pk(1000, -1000, 200, -200), pe(127, -128, 127, -128), 1, 0);
    drain();
    chk("t6_near_full", 64'(sat_count), 64'd65532);
    send(pk(1000, -1000, 200, -200), pe(127, -128, 127, -128), 1, 0);
    drain();
    chk("t6_full", 64'(sat_count), 64'hFFFF);
    send(pk(1000, -1000, 200, -200), pe(127, -128, 127, -128), 1, 0);
    drain();
    chk("t6_sticky", 64'(sat_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/activation_requant_unit.md
Name: activation_requant_unit

Overview:
Multi-lane activation and requantisation stage placed between the accumulator array and the output buffer.
- Applies a selectable activation (identity, ReLU, leaky ReLU, clipped ReLU) to ACC_W-bit signed accumulators.
- Rescales each result by a rounding arithmetic right shift and saturates it to OUT_W-bit signed.
- Two-stage pipeline with full valid/ready backpressure and a saturation-event counter.

Parameters:
- ACC_W, 40, signed accumulator width per lane
- OUT_W, 8, signed output width per lane
- LANES, 4, number of parallel lanes sharing one handshake
- SHIFT_W, 6, width of the requantisation shift field

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_mode  in  2  0 = identity, 1 = ReLU, 2 = leaky ReLU, 3 = clipped ReLU
- cfg_shift  in  SHIFT_W  requantisation right-shift amount
- cfg_leak_shift  in  4  leaky ReLU negative-slope shift (slope = 2^-n)
- cfg_clip  in  OUT_W-1  unsigned clip ceiling for mode 3, in the output domain
- in_data  in  LANES*ACC_W  packed signed accumulators; lane 0 in the LSBs
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- out_data  out  LANES*OUT_W  packed signed results; lane 0 in the LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  16  saturating count of lanes that overflowed OUT_W

Behaviour:
- Accept condition: a beat is accepted when in_valid && in_ready.
  - All cfg_* values are sampled with the beat and travel with it down the pipeline.
  - A cfg change takes effect from the next accepted beat; in-flight beats are unaffected.
- Pipeline: stage S1 (activation) and stage S2 (requant + saturate + clip), each a registered valid/data pair.
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready && rst_n
- Latency and throughput: out_valid rises exactly 2 cycles after acceptance when the pipeline is not stalled. Throughput is 1 beat per cycle.
- Stall: while out_valid && !out_ready, out_data and out_valid are held stable. No beat is dropped, duplicated or reordered.
- Activation (S1, ACC_W+1 bits), for x < 0:
  - mode 0 → x
  - modes 1 and 3 → 0
  - mode 2 → x >>> cfg_leak_shift (arithmetic, floor)
  - For x >= 0 the value passes unchanged in all modes.
- Requantisation (S2):
  - s = min(cfg_shift, ACC_W-1).
  - If s = 0 the value is unchanged.
  - Otherwise r = (a + 2^(s-1)) >>> s, computed at ACC_W+1 bits with no overflow (round half toward +inf).
- Saturation: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The lane's sat flag is set if clamping changed the value.
- Clip (mode 3 only): out = min(sat_value, cfg_clip), applied after saturation.
  - The clip itself never sets the sat flag.
- sat_count:
  - On each output handshake (out_valid && out_ready), add the number of set lane sat flags of that beat.
  - Sticks at 16'hFFFF.
  - sat_clr has priority: in a cycle with both sat_clr and an increment, the count becomes 0 and that increment is dropped.
- Reset (synchronous):
  - s1_valid, s2_valid, out_valid = 0; out_data = 0; sat_count = 0; in_ready = 0 while rst_n is low.
  - Reset mid-stream discards all in-flight beats; no out_valid is produced for them after release.
  - in_ready = 1 in the first cycle after release.
- No X propagation: the data registers load only on their stage's handshake; pipeline registers are not reset-dependent beyond the valid bits and out_data.

Test Plan (ACC_W=40, OUT_W=8, LANES=4):
1. Mode 1, shift 0, lanes {0, -1, 1, 127}, out_ready=1 → {0, 0, 1, 127}; out_valid exactly 2 cycles after accept; sat_count stays 0.
2. Mode 2, leak 3, shift 0, lanes {-64, -1, 100, -2000} → {-8, -1, 100, -128}; sat_count increments by 1.
3. Mode 0, shift 4, lanes {24, 23, -24, 5000} → {2, 1, -1, 127}; sat_count +1. Then shift 0 with lane value -(2^39) → -128.
4. Mode 3, clip 6, shift 0, lanes {-5, 3, 6, 100} → {0, 3, 6, 6}; sat_count unchanged. Change cfg_mode to 1 on the cycle after accept → that beat is still clipped.
5. Stream 10 back-to-back beats (lane0 = 1..10) with out_ready low for 3 cycles mid-stream:
   - in_ready falls once S1 and S2 are full.
   - out_data is held stable during the stall.
   - Outputs arrive 1..10 in order, with no gaps after the stall clears.
6. Reset and counter corner cases:
   - Assert rst_n=0 for 1 cycle with 2 beats in flight → no outputs from those beats; in_ready=1 the next cycle.
   - Assert sat_clr in the same cycle as a saturating output handshake → sat_count=0.
   - Preload the counter to 16'hFFFF → it stays at 16'hFFFF.
